// File: rtl/fft_out_reorder.sv
// Output reorder stage for the 32-point pipelined FFT. It takes bit-reversed two-lane frames and
// emits one natural-order bin per cycle. Two ping-pong banks let one frame fill while the other drains.
module fft_out_reorder #(
  parameter int unsigned DW    = 17,
  parameter int unsigned LOG2N = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [DW-1:0]    Y0_re,
  input  logic [DW-1:0]    Y0_im,
  input  logic [DW-1:0]    Y1_re,
  input  logic [DW-1:0]    Y1_im,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic [LOG2N-1:0] out_index,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned Half = 1 << (LOG2N - 1);

  typedef enum logic {WrIdle, WrFill} wr_state_t;
  typedef enum logic {RdIdle, RdRead} rd_state_t;

  wr_state_t        wr_state_q, wr_state_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic [LOG2N-2:0] wr_cnt_q, wr_cnt_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [LOG2N-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, rd_en, set_full, clr_full;
  logic [LOG2N-2:0] wr_beat;

  // Lane 0 carries bins 0..Half-1, lane 1 bins Half..N-1: one half-array per lane.
  logic [2*DW-1:0] mem_lo [2*Half];
  logic [2*DW-1:0] mem_hi [2*Half];

  function automatic logic [LOG2N-2:0] bit_rev(input logic [LOG2N-2:0] a);
    logic [LOG2N-2:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2N) - 1; i++) r[i] = a[int'(LOG2N) - 2 - i];
    return r;
  endfunction

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_beat    = wr_cnt_q;
    set_full   = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        if (in_valid && in_first) begin
          if (full_q[wr_ptr_q]) begin
            overflow_d = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_beat    = '0;
            wr_cnt_d   = {{(LOG2N-2){1'b0}}, 1'b1};
            wr_state_d = WrFill;
          end
        end
      end
      WrFill: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_first) begin
            // Restart discards the partial frame; the bank is still ours.
            wr_beat  = '0;
            wr_cnt_d = {{(LOG2N-2){1'b0}}, 1'b1};
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == '1) begin
              set_full   = 1'b1;
              wr_ptr_d   = ~wr_ptr_q;
              wr_state_d = WrIdle;
            end
          end
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_addr_d  = rd_addr_q;
    rd_en      = 1'b0;
    clr_full   = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        if (full_q[rd_ptr_q]) rd_state_d = RdRead;
      end
      RdRead: begin
        rd_en     = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == '1) begin
          clr_full = 1'b1;
          rd_ptr_d = ~rd_ptr_q;
          if (!full_q[~rd_ptr_q]) rd_state_d = RdIdle;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Writer and reader never own the same bank, so set and clear hit different bits.
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wr_ptr_q] = 1'b1;
    if (clr_full) full_d[rd_ptr_q] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_addr_q  <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_addr_q  <= rd_addr_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_lo[{wr_ptr_q, bit_rev(wr_beat)}] <= {Y0_re, Y0_im};
      mem_hi[{wr_ptr_q, bit_rev(wr_beat)}] <= {Y1_re, Y1_im};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_first <= (rd_addr_q == '0);
      out_last  <= (rd_addr_q == '1);
      out_index <= rd_addr_q;
      if (rd_addr_q[LOG2N-1]) begin
        {out_re, out_im} <= mem_hi[{rd_ptr_q, rd_addr_q[LOG2N-2:0]}];
      end else begin
        {out_re, out_im} <= mem_lo[{rd_ptr_q, rd_addr_q[LOG2N-2:0]}];
      end
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end
  end

  assign overflow = overflow_q;
  assign busy     = (|full_q) || (rd_state_q == RdRead) || (wr_state_q == WrFill);

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: frames are built in natural order, sent bit-reversed,
// and a negedge monitor checks every output bin against the queued expectation.
module tb_fft_out_reorder;

  logic        Clk, Reset, in_valid, in_first;
  logic [16:0] Y0_re, Y0_im, Y1_re, Y1_im;
  logic        out_valid, out_first, out_last, overflow, busy;
  logic [4:0]  out_index;
  logic [16:0] out_re, out_im;

  fft_out_reorder #(.DW(17), .LOG2N(5)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_first(in_first),
    .Y0_re(Y0_re), .Y0_im(Y0_im), .Y1_re(Y1_re), .Y1_im(Y1_im),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .out_index(out_index),
    .out_re(out_re), .out_im(out_im), .overflow(overflow), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_re_q[$], exp_im_q[$], exp_idx_q[$], lat_q[$];
  int bin_re[32], bin_im[32];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int rev4(input int j);
    int r = 0;
    for (int b = 0; b < 4; b++) if ((j >> b) & 1) r |= 1 << (3 - b);
    return r;
  endfunction

  function automatic int sx(input logic [16:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ramp(input int off);
    for (int k = 0; k < 32; k++) begin
      bin_re[k] = k + off;
      bin_im[k] = -k;
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < 32; k++) begin
      bin_re[k] = int'($urandom_range(0, 131071)) - 65536;
      bin_im[k] = int'($urandom_range(0, 131071)) - 65536;
    end
  endtask

  task automatic drive_garbage();
    in_valid = 1'b0;
    in_first = 1'($urandom_range(0, 1));
    Y0_re = 17'($urandom); Y0_im = 17'($urandom);
    Y1_re = 17'($urandom); Y1_im = 17'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      drive_garbage();
    end
  endtask

  // Beat j carries bin rev4(j) on lane 0 and bin rev4(j)+16 on lane 1.
  task automatic send_frame(input int stall_after, input int stall_len, input bit accept,
                            input bit chk_lat, input bit chk_ovf);
    int last_edge = 0;
    if (accept) begin
      for (int k = 0; k < 32; k++) begin
        exp_re_q.push_back(bin_re[k]);
        exp_im_q.push_back(bin_im[k]);
        exp_idx_q.push_back(k);
      end
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge Clk);
      if (chk_ovf && j == 0) chk("overflow_before_drop", int'(overflow), 0);
      if (chk_ovf && j == 1) chk("overflow_on_drop", int'(overflow), 1);
      in_valid = 1'b1;
      in_first = (j == 0);
      Y0_re = 17'(bin_re[rev4(j)]);
      Y0_im = 17'(bin_im[rev4(j)]);
      Y1_re = 17'(bin_re[rev4(j) + 16]);
      Y1_im = 17'(bin_im[rev4(j) + 16]);
      last_edge = cyc + 1;
      if (j == stall_after) idle(stall_len);
    end
    if (accept) lat_q.push_back(chk_lat ? last_edge + 2 : -1);
  endtask

  task automatic wait_idle();
    int n = 0;
    idle(1);
    while (!(exp_re_q.size() == 0 && !busy && !out_valid) && n < 400) begin
      @(negedge Clk);
      drive_garbage();
      n++;
    end
    chk("drain_in_time", int'(n < 400), 1);
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (out_valid) begin
        if (exp_re_q.size() == 0) begin
          chk("unexpected_out_valid", int'(out_valid), 0);
        end else begin
          int er, ei, ek, lat;
          er = exp_re_q.pop_front();
          ei = exp_im_q.pop_front();
          ek = exp_idx_q.pop_front();
          chk("out_re", sx(out_re), er);
          chk("out_im", sx(out_im), ei);
          chk("out_index", int'(out_index), ek);
          chk("out_first", int'(out_first), int'(ek == 0));
          chk("out_last", int'(out_last), int'(ek == 31));
          if (ek == 0) begin
            lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
            if (lat >= 0) chk("first_bin_latency", cyc, lat);
          end
        end
      end else begin
        chk("idle_re_zero", sx(out_re), 0);
        chk("idle_im_zero", sx(out_im), 0);
        chk("idle_index_zero", int'(out_index), 0);
        chk("idle_framing_zero", int'({out_first, out_last}), 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    drive_garbage();
    in_first = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", sx(out_re) | sx(out_im) | int'(out_index), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overflow", int'(overflow), 0);
    Reset = 1'b0;
    idle(2);

    // Identity ramp, extremes, and a stalled ramp
    set_ramp(0);
    send_frame(-1, 0, 1, 1, 0);
    chk("busy_while_full", int'(busy), 1);
    wait_idle();
    set_random();
    bin_re[0] = -65536; bin_im[0] = 65535;
    bin_re[16] = 65535; bin_im[16] = -65536;
    send_frame(-1, 0, 1, 1, 0);
    wait_idle();
    set_ramp(0);
    send_frame(5, 3, 1, 1, 0);
    wait_idle();

    // Back-to-back: in_first 32 cycles apart; latency of frame 2 implies gapless output
    set_ramp(0);
    send_frame(-1, 0, 1, 1, 0);
    idle(16);
    set_ramp(100);
    send_frame(-1, 0, 1, 1, 0);
    wait_idle();
    chk("overflow_after_b2b", int'(overflow), 0);

    // Overflow: three frames 16 cycles apart, third dropped
    set_ramp(200);
    send_frame(-1, 0, 1, 1, 0);
    set_ramp(300);
    send_frame(-1, 0, 1, 0, 0);
    set_ramp(400);
    send_frame(-1, 0, 0, 0, 1);
    wait_idle();
    chk("overflow_sticky", int'(overflow), 1);

    // Random frames with random stalls
    for (int f = 0; f < 5; f++) begin
      set_random();
      send_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 4)), 1, 1, 0);
      idle(16 + int'($urandom_range(0, 6)));
    end
    wait_idle();
    chk("overflow_still_sticky", int'(overflow), 1);

    // Reset in the middle of a read
    begin
      int n = 0;
      set_ramp(0);
      send_frame(-1, 0, 1, 1, 0);
      idle(1);
      while (!(out_valid && out_index == 5'd10) && n < 100) begin
        @(negedge Clk);
        n++;
      end
      chk("reached_bin10", int'(n < 100), 1);
    end
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_out_re", sx(out_re), 0);
    chk("rst_mid_out_im", sx(out_im), 0);
    chk("rst_mid_out_index", int'(out_index), 0);
    chk("rst_mid_framing", int'({out_first, out_last}), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_overflow", int'(overflow), 0);
    exp_re_q.delete(); exp_im_q.delete(); exp_idx_q.delete(); lat_q.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    idle(1);
    set_ramp(7);
    send_frame(-1, 0, 1, 1, 0);
    wait_idle();
    chk("overflow_after_reset", int'(overflow), 0);
    chk("leftover_expected", exp_re_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
